// File: rtl/alu_pkg.sv
// Shared ALU / mul-div package.
// Control codes, op and state enums.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLTU = 4'b0111;

  localparam int MULDIV_ITERS = 32;

  typedef enum logic [1:0] {
    MUL   = 2'b00,
    MULHU = 2'b01,
    DIVU  = 2'b10,
    REMU  = 2'b11
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } muldiv_state_e;

endpackage

// File: rtl/alu_muldiv_seq_if.sv
// Start/result handshake bundle
// for the mul/div sequencer.
interface alu_muldiv_seq_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        ready;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] result;

  modport master (
    output start, op, src1, src2,
    output res_ready,
    input  ready, res_valid, result
  );

  modport slave (
    input  start, op, src1, src2,
    input  res_ready,
    output ready, res_valid, result
  );
endinterface

// File: rtl/alu.sv
// Core integer ALU, reused by the
// mul/div sequencer for add/sub steps.
import alu_pkg::*;

module alu (
  input  logic [3:0]  alu_ctrl_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o,
  output logic        zero_o
);

  // combinational operation select
  always_comb begin
    y_o = '0;
    case (alu_ctrl_i)
      ALU_ADD:  y_o = a_i + b_i;
      ALU_SUB:  y_o = a_i - b_i;
      ALU_SLTU: y_o = {31'b0, a_i < b_i};
      default:  y_o = '0;
    endcase
  end

  assign zero_o = (y_o == '0);

endmodule

// File: rtl/alu_muldiv_seq.sv
// Iterative MUL/MULHU/DIVU/REMU unit,
// one radix-2 step per cycle.
import alu_pkg::*;

module alu_muldiv_seq (
  input  logic             clk,
  input  logic             rst_n,
  alu_muldiv_seq_if.slave  bus
);

  muldiv_state_e state_q, state_d;
  muldiv_op_e    op_q, op_d, op_in;
  logic [5:0]    cnt_q, cnt_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic [31:0]   res_q, res_d;

  logic [3:0]    alu_ctrl;
  logic [31:0]   alu_a, alu_y;
  logic          alu_zero_unused;
  logic          is_mul, carry, no_borrow;
  logic [32:0]   rem_sh;

  assign op_in = muldiv_op_e'(bus.op);

  alu u_alu (
    .alu_ctrl_i (alu_ctrl),
    .a_i        (alu_a),
    .b_i        (a_q),
    .y_o        (alu_y),
    .zero_o     (alu_zero_unused)
  );

  // ALU operand steering and carry/borrow
  always_comb begin
    is_mul    = (op_q == MUL) || (op_q == MULHU);
    rem_sh    = {hi_q, lo_q[31]};
    alu_ctrl  = is_mul ? ALU_ADD : ALU_SUB;
    alu_a     = is_mul ? hi_q : rem_sh[31:0];
    carry     = alu_y < a_q;
    no_borrow = rem_sh[32] || (rem_sh[31:0] >= a_q);
  end

  // next state and datapath update
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d  = op_in;
          cnt_d = '0;
          hi_d  = '0;
          if (op_in == MUL || op_in == MULHU) begin
            a_d  = bus.src1;
            lo_d = bus.src2;
          end else begin
            a_d  = bus.src2;
            lo_d = bus.src1;
          end
          if ((op_in == DIVU || op_in == REMU)
              && bus.src2 == '0) begin
            state_d = DONE;
            res_d   = (op_in == DIVU) ? '1
                                      : bus.src1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        cnt_d = cnt_q + 6'd1;
        if (is_mul) begin
          if (lo_q[0]) begin
            hi_d = {carry, alu_y[31:1]};
            lo_d = {alu_y[0], lo_q[31:1]};
          end else begin
            hi_d = {1'b0, hi_q[31:1]};
            lo_d = {hi_q[0], lo_q[31:1]};
          end
        end else begin
          hi_d = no_borrow ? alu_y
                           : rem_sh[31:0];
          lo_d = {lo_q[30:0], no_borrow};
        end
        if (cnt_q == 6'(MULDIV_ITERS - 1)) begin
          state_d = DONE;
          unique case (op_q)
            MUL:   res_d = lo_d;
            MULHU: res_d = hi_d;
            DIVU:  res_d = lo_d;
            REMU:  res_d = hi_d;
          endcase
        end
      end
      DONE: begin
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= MUL;
      cnt_q   <= '0;
      a_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      res_q   <= res_d;
    end
  end

  assign bus.ready     = (state_q == IDLE);
  assign bus.res_valid = (state_q == DONE);
  assign bus.result    = res_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq:
// vector table plus handshake/reset corners.
module tb_alu_muldiv_seq;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   applied = 0;
  int   miscompares = 0;

  alu_muldiv_seq_if bus();

  alu_muldiv_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h",
               nm, act, exp);
    end
  endtask

  task automatic run_op(input logic [1:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        output logic [31:0] r,
                        output int lat,
                        output logic rdy_low);
    bus.op    = op;
    bus.src1  = a;
    bus.src2  = b;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat     = 1;
    rdy_low = 1'b1;
    while (!bus.res_valid && lat < 100) begin
      rdy_low &= ~bus.ready;
      @(posedge clk); #1;
      lat++;
    end
    rdy_low &= ~bus.ready;
    r = bus.result;
  endtask

  task automatic handshake(input string nm);
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    chk({nm, "_ready_after"}, 32'(bus.ready), 1);
    chk({nm, "_valid_after"},
        32'(bus.res_valid), 0);
  endtask

  initial begin
    vec_t        v [14];
    logic [31:0] r;
    int          lat;
    logic        rl;
    logic        stable;

    v[0]  = '{2'b00, 32'd7, 32'd6,
              32'h0000002A, 33};
    v[1]  = '{2'b00, 32'hFFFFFFFF,
              32'hFFFFFFFF, 32'h00000001, 33};
    v[2]  = '{2'b01, 32'hFFFFFFFF,
              32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    v[3]  = '{2'b10, 32'd100, 32'd7,
              32'h0000000E, 33};
    v[4]  = '{2'b11, 32'd100, 32'd7,
              32'h00000002, 33};
    v[5]  = '{2'b10, 32'h80000000, 32'd1,
              32'h80000000, 33};
    v[6]  = '{2'b10, 32'd5, 32'd0,
              32'hFFFFFFFF, 1};
    v[7]  = '{2'b11, 32'd5, 32'd0,
              32'h00000005, 1};
    v[8]  = '{2'b00, 32'h00010000,
              32'h00010000, 32'h00000000, 33};
    v[9]  = '{2'b01, 32'h00010000,
              32'h00010000, 32'h00000001, 33};
    v[10] = '{2'b10, 32'hFFFFFFFF,
              32'hFFFFFFFF, 32'h00000001, 33};
    v[11] = '{2'b11, 32'hFFFFFFFF,
              32'h00000010, 32'h0000000F, 33};
    v[12] = '{2'b10, 32'd3, 32'd5,
              32'h00000000, 33};
    v[13] = '{2'b11, 32'd3, 32'd5,
              32'h00000003, 33};

    bus.start     = 1'b0;
    bus.op        = 2'b00;
    bus.src1      = '0;
    bus.src2      = '0;
    bus.res_ready = 1'b0;

    #12;
    chk("rst_ready", 32'(bus.ready), 1);
    chk("rst_valid", 32'(bus.res_valid), 0);
    chk("rst_result", bus.result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      chk($sformatf("v%0d_ready_in", i),
          32'(bus.ready), 1);
      run_op(v[i].op, v[i].a, v[i].b,
             r, lat, rl);
      chk($sformatf("v%0d_result", i),
          r, v[i].exp);
      chk($sformatf("v%0d_latency", i),
          32'(lat), 32'(v[i].lat));
      chk($sformatf("v%0d_ready_low", i),
          32'(rl), 1);
      handshake($sformatf("v%0d", i));
    end

    // backpressure with ignored starts
    run_op(2'b00, 32'd7, 32'd6, r, lat, rl);
    chk("bp_result", r, 32'h2A);
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus.start = 1'b1;
      bus.op    = 2'(k);
      bus.src1  = 32'(k + 11);
      bus.src2  = 32'(k);
      @(posedge clk); #1;
      stable &= bus.res_valid & ~bus.ready;
      stable &= (bus.result == 32'h2A);
    end
    bus.start = 1'b0;
    chk("bp_stable", 32'(stable), 1);
    handshake("bp");
    run_op(2'b10, 32'd100, 32'd7, r, lat, rl);
    chk("bp_next_result", r, 32'h0E);
    chk("bp_next_latency", 32'(lat), 33);
    handshake("bp_next");

    // res_ready raised before res_valid
    bus.res_ready = 1'b1;
    run_op(2'b11, 32'd5, 32'd0, r, lat, rl);
    chk("early_rr_result", r, 32'h5);
    chk("early_rr_latency", 32'(lat), 1);
    @(posedge clk); #1;
    chk("early_rr_ready", 32'(bus.ready), 1);
    bus.res_ready = 1'b0;

    // reset at CALC iteration 10
    bus.op    = 2'b00;
    bus.src1  = 32'hFFFFFFFF;
    bus.src2  = 32'hFFFFFFFF;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_busy", 32'(bus.ready), 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.res_valid), 0);
    chk("mid_rst_result", bus.result, 0);
    chk("mid_rst_ready", 32'(bus.ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(2'b00, 32'd3, 32'd3, r, lat, rl);
    chk("post_rst_result", r, 32'h9);
    chk("post_rst_latency", 32'(lat), 33);
    handshake("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==",
             applied, miscompares);
    $finish;
  end

endmodule
